// File: rtl/drop_engine.sv
// Hard-drop / gravity engine: lowers a snapshotted brick one row per step until it lands.
// Optional macro DROP_TICK_EN adds a drop_tick input that paces each step for animated falls.

`ifndef POS_LEN
`define POS_LEN 10
`endif
`ifndef BRICK_LEN
`define BRICK_LEN 3
`endif
`ifndef DIR_LEN
`define DIR_LEN 2
`endif

// Expands an origin/type/rotation into four cells; offsets are non-negative from the bottom-left origin.
module brick #(
  parameter int COL_BITS = 5,
  parameter int POS_W    = `POS_LEN
) (
  input  logic [POS_W-1:0]          pos,
  input  logic [`BRICK_LEN-1:0]     brick_type,
  input  logic [`DIR_LEN-1:0]       dir,
  output logic [POS_W-COL_BITS:0]   cell_row [4],
  output logic [COL_BITS:0]         cell_col [4]
);
  localparam int RW = POS_W - COL_BITS + 1;
  localparam int CW = COL_BITS + 1;

  // Each nibble is one cell as {row_offset[1:0], col_offset[1:0]}, cell 0 in the top nibble.
  logic [15:0] offs;
  logic [3:0]  nib;

  always_comb begin
    offs = 16'h0145;
    case (brick_type)
      3'd0: offs = dir[0] ? 16'h048C : 16'h0123;
      3'd1: offs = 16'h0145;
      3'd2: case (dir)
              2'd0: offs = 16'h0125;
              2'd1: offs = 16'h0485;
              2'd2: offs = 16'h4561;
              default: offs = 16'h1594;
            endcase
      3'd3: offs = dir[0] ? 16'h4815 : 16'h0156;
      3'd4: offs = dir[0] ? 16'h0459 : 16'h4512;
      3'd5: case (dir)
              2'd0: offs = 16'h0124;
              2'd1: offs = 16'h0489;
              2'd2: offs = 16'h4562;
              default: offs = 16'h0159;
            endcase
      3'd6: case (dir)
              2'd0: offs = 16'h0126;
              2'd1: offs = 16'h0148;
              2'd2: offs = 16'h0456;
              default: offs = 16'h8159;
            endcase
      default: offs = 16'h0145;
    endcase
  end

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < 4; i++) begin
      nib = offs[15-4*i -: 4];
      cell_row[i] = {1'b0, pos[POS_W-1:COL_BITS]} + RW'(nib[3:2]);
      cell_col[i] = {1'b0, pos[COL_BITS-1:0]} + CW'(nib[1:0]);
    end
  end
endmodule

module drop_engine #(
  parameter int BOARD_W  = 10,
  parameter int BOARD_H  = 20,
  parameter int COL_BITS = 5,
  parameter int CNT_W    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
`ifdef DROP_TICK_EN
  input  logic                         drop_tick,
`endif
  input  logic [BOARD_W*BOARD_H-1:0]   cur_board,
  input  logic [`POS_LEN-1:0]          pos,
  input  logic [`BRICK_LEN-1:0]        brick_type,
  input  logic [`DIR_LEN-1:0]          dir,
  output logic                         busy,
  output logic                         done,
  output logic [`POS_LEN-1:0]          new_pos,
  output logic [CNT_W-1:0]             rows_dropped
);
  localparam int POS_W = `POS_LEN;
  localparam int RW    = POS_W - COL_BITS + 1;
  localparam int CW    = COL_BITS + 1;
  localparam int CELLS = BOARD_W * BOARD_H;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [CW-1:0] BOARD_W_C = CW'(BOARD_W);
  localparam logic [RW-1:0] BOARD_H_R = RW'(BOARD_H);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] PROBE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [CELLS-1:0]      snap_board;
  logic [POS_W-1:0]      snap_pos;
  logic [`BRICK_LEN-1:0] snap_type;
  logic [`DIR_LEN-1:0]   snap_dir;
  logic [POS_W-1:0]      probe;
  logic [CNT_W-1:0]      cnt;

  logic [RW-1:0]         cell_row [4];
  logic [CW-1:0]         cell_col [4];
  logic [RW-1:0]         below_row;
  logic [IDX_W-1:0]      idx;
  logic                  step_legal;
  logic                  step_en;

  brick #(.COL_BITS(COL_BITS), .POS_W(POS_W)) u_brick (
    .pos        (probe),
    .brick_type (snap_type),
    .dir        (snap_dir),
    .cell_row   (cell_row),
    .cell_col   (cell_col)
  );

`ifdef DROP_TICK_EN
  assign step_en = drop_tick;
`else
  assign step_en = 1'b1;
`endif

  assign busy = (state != IDLE);

  // A row-0 cell blocks before the subtraction is used, so below_row never wraps into a board index.
  always_comb begin
    step_legal = 1'b1;
    below_row  = '0;
    idx        = '0;
    for (int i = 0; i < 4; i++) begin
      below_row = cell_row[i] - RW'(1);
      idx       = '0;
      if (cell_row[i] == '0 || cell_col[i] >= BOARD_W_C) begin
        step_legal = 1'b0;
      end else if (below_row < BOARD_H_R) begin
        idx = IDX_W'(below_row) * IDX_W'(BOARD_W) + IDX_W'(cell_col[i]);
        if (snap_board[idx]) step_legal = 1'b0;
      end
    end
  end

  // Results are latched on the PROBE->DONE edge so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      snap_board   <= '0;
      snap_pos     <= '0;
      snap_type    <= '0;
      snap_dir     <= '0;
      probe        <= '0;
      cnt          <= '0;
      new_pos      <= '0;
      rows_dropped <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_board <= cur_board;
            snap_pos   <= pos;
            snap_type  <= brick_type;
            snap_dir   <= dir;
            state      <= LOAD;
          end
        end
        LOAD: begin
          probe <= snap_pos;
          cnt   <= '0;
          state <= PROBE;
        end
        PROBE: begin
          if (step_en) begin
            if (step_legal) begin
              probe <= probe - (POS_W'(1) << COL_BITS);
              cnt   <= cnt + CNT_W'(1);
            end else begin
              new_pos      <= probe;
              rows_dropped <= cnt;
              done         <= 1'b1;
              state        <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
